// File: rtl/wgt_feed_pkg.sv
// wgt_feed_pkg: shared constants, state encoding and lane-slice helpers for
// the weight skew feeder and its lane delay lines.
package wgt_feed_pkg;

  localparam int SYSTOLIC_SIZE_DEF = 16;
  localparam int DATA_WIDTH_DEF    = 16;
  localparam int KERNEL_SIZE_DEF   = 3;
  localparam int NO_CHANNEL_DEF    = 3;
  localparam int RD_LATENCY_DEF    = 1;

  // Words per weight tile for the default kernel geometry.
  localparam int TILE_LEN = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF * NO_CHANNEL_DEF;

  // Consecutive idle FILL cycles tolerated before a tile is flagged as short.
  localparam int STALL_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } feed_state_e;

  // Words per tile for an arbitrary kernel geometry.
  function automatic int tile_len(input int kernel, input int channels);
    return kernel * kernel * channels;
  endfunction

  // Low bit index of lane 'lane' in a packed row of 'dw'-bit lanes.
  function automatic int lane_lo(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/wgt_lane_delay.sv
// wgt_lane_delay: fixed-depth shift line carrying one weight lane and its
// valid bit in lockstep; every stage advances every cycle.
module wgt_lane_delay #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  vld_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  vld_out
);

  logic [DATA_WIDTH-1:0] dat_p [DEPTH];
  logic [DEPTH-1:0]      vld_p;

  // Free-running shift chain; a bubble travels as valid=0 with zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int k = 0; k < DEPTH; k++) dat_p[k] <= '0;
    end else begin
      vld_p[0] <= vld_in;
      dat_p[0] <= data_in;
      for (int k = 1; k < DEPTH; k++) begin
        vld_p[k] <= vld_p[k-1];
        dat_p[k] <= dat_p[k-1];
      end
    end
  end

  assign data_out = dat_p[DEPTH-1];
  assign vld_out  = vld_p[DEPTH-1];

endmodule

// File: rtl/wgt_skew_feeder.sv
// wgt_skew_feeder: aligns weight SRAM rows with the address controller's
// read strobe and filter count, zeroes inactive lanes, skews lane i by i+1
// cycles toward the systolic array and pulses tile_done when the last word
// of a tile has left the final lane.
// Build option: define WGT_TILE_CNT_EN to add the tile_cnt and err_short
// outputs together with their counter logic.
module wgt_skew_feeder
  import wgt_feed_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = SYSTOLIC_SIZE_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int KERNEL_SIZE   = KERNEL_SIZE_DEF,
  parameter int NO_CHANNEL    = NO_CHANNEL_DEF,
  parameter int RD_LATENCY    = RD_LATENCY_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                rd_en_in,
  input  logic [4:0]                          size_in,
  input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] wgt_rdata,
  output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] wgt_out,
  output logic [SYSTOLIC_SIZE-1:0]            wgt_valid,
  output logic                                tile_done,
`ifdef WGT_TILE_CNT_EN
  output logic [15:0]                         tile_cnt,
  output logic                                err_short,
`endif
  output logic                                busy
);

  localparam int         TILE_WORDS = tile_len(KERNEL_SIZE, NO_CHANNEL);
  localparam logic [4:0] LAST_IDX   = 5'(TILE_WORDS - 1);
  localparam int         DCW        = $clog2(SYSTOLIC_SIZE + 1);

  // Filter counts above the array width select every lane.
  function automatic logic [4:0] clamp_size(input logic [4:0] sz);
    if (int'(sz) > SYSTOLIC_SIZE) return 5'(SYSTOLIC_SIZE);
    return sz;
  endfunction

  // ---- alignment stage: strobe and size delayed to match SRAM read data ----
  logic [RD_LATENCY-1:0] vld_p;
  logic [4:0]            size_p [RD_LATENCY];
  logic                  v_al;
  logic [4:0]            s_al;

  // Delay rd_en_in/size_in by the SRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int k = 0; k < RD_LATENCY; k++) size_p[k] <= '0;
    end else begin
      vld_p[0]  <= rd_en_in;
      size_p[0] <= size_in;
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld_p[k]  <= vld_p[k-1];
        size_p[k] <= size_p[k-1];
      end
    end
  end

  assign v_al = vld_p[RD_LATENCY-1];
  assign s_al = size_p[RD_LATENCY-1];

  // ---- word counting and per-tile size latch ----
  logic [4:0] word_cnt;
  logic [4:0] size_lat;
  logic [4:0] size_cur;
  logic       first_word;
  logic       last_word;

  assign first_word = (word_cnt == 5'd0);
  assign last_word  = v_al && (word_cnt == LAST_IDX);
  // The first word of a tile is masked with its own size, later words with
  // the value latched from that first word.
  assign size_cur   = first_word ? clamp_size(s_al) : size_lat;

  // Count aligned words, wrapping at the end of each tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (v_al) begin
      word_cnt <= last_word ? 5'd0 : word_cnt + 5'd1;
    end
  end

  // Capture the filter count on the first aligned word of every tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_lat <= '0;
    end else if (v_al && first_word) begin
      size_lat <= clamp_size(s_al);
    end
  end

  // ---- masking and skew stage: lane i delayed by i+1 registers ----
  for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_d;
    logic [DATA_WIDTH-1:0] lane_q;
    logic                  lane_v;

    // Inactive lanes and bubbles carry zero data; valid follows v_al for
    // every lane so the array columns stay in lockstep.
    assign lane_d = (v_al && (5'(i) < size_cur)) ?
                    wgt_rdata[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] : '0;

    wgt_lane_delay #(
      .DEPTH      (i + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_dly (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (lane_d),
      .vld_in   (v_al),
      .data_out (lane_q),
      .vld_out  (lane_v)
    );

    assign wgt_out[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] = lane_q;
    assign wgt_valid[i] = lane_v;
  end

  // ---- tile control FSM ----
  feed_state_e      state, state_nxt;
  logic [DCW-1:0]   drain_cnt, drain_cnt_nxt;
  logic             pending, pending_nxt;

  // State, drain counter and pending-tile flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
      pending   <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      pending   <= pending_nxt;
    end
  end

  // Next-state logic. drain_cnt counts the skew stages still ahead of the
  // last word: it has already entered lane 0 when DRAIN begins, so the count
  // reaches zero exactly when that word sits on the final lane's output.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    pending_nxt   = pending;
    case (state)
      IDLE: begin
        if (v_al) state_nxt = FILL;
      end
      FILL: begin
        if (last_word) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = DCW'(SYSTOLIC_SIZE - 1);
          pending_nxt   = 1'b0;
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt   = (pending || v_al) ? FILL : IDLE;
          pending_nxt = 1'b0;
        end else begin
          drain_cnt_nxt = drain_cnt - 1'b1;
          if (v_al) pending_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign tile_done = (state == DRAIN) && (drain_cnt == '0);
  assign busy      = (state != IDLE);

`ifdef WGT_TILE_CNT_EN
  logic [2:0] stall_cnt;
  logic       stall;

  assign stall = (state == FILL) && (word_cnt != 5'd0) && !v_al;

  // Completed-tile counter, wrapping at 2^16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_cnt <= '0;
    end else if (tile_done) begin
      tile_cnt <= tile_cnt + 16'd1;
    end
  end

  // Sticky short-tile flag: a partial tile idle for more than STALL_LIMIT
  // consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      err_short <= 1'b0;
    end else if (stall) begin
      if (stall_cnt != 3'b111) stall_cnt <= stall_cnt + 3'd1;
      if (stall_cnt >= 3'(STALL_LIMIT)) err_short <= 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_wgt_skew_feeder.sv
// tb_wgt_skew_feeder: directed bench for wgt_skew_feeder with an SRAM of one
// cycle read latency modelled inline. Outputs are logged #1 after each rising
// edge and compared against skew/mask/timing values derived from the stimulus.
module tb_wgt_skew_feeder;
  import wgt_feed_pkg::*;

  localparam int SS   = 16;
  localparam int DW   = 16;
  localparam int BW   = SS * DW;
  localparam int NLOG = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en_in = 1'b0;
  logic [4:0]    size_in = '0;
  logic [BW-1:0] wgt_rdata = '0;
  logic [BW-1:0] wgt_out;
  logic [SS-1:0] wgt_valid;
  logic          tile_done;
  logic          busy;
`ifdef WGT_TILE_CNT_EN
  logic [15:0]   tile_cnt;
  logic          err_short;
`endif

  wgt_skew_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en_in  (rd_en_in),
    .size_in   (size_in),
    .wgt_rdata (wgt_rdata),
    .wgt_out   (wgt_out),
    .wgt_valid (wgt_valid),
    .tile_done (tile_done),
`ifdef WGT_TILE_CNT_EN
    .tile_cnt  (tile_cnt),
    .err_short (err_short),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int            npass = 0;
  int            nchk  = 0;
  int            n     = 0;
  logic [BW-1:0] rdata_q = '0;
  logic          stim_rd  [NLOG];
  int            stim_sz  [NLOG];
  logic [BW-1:0] stim_dat [NLOG];
  logic [SS-1:0] log_v    [NLOG];
  logic [BW-1:0] log_o    [NLOG];
  logic          log_done [NLOG];
  logic          log_busy [NLOG];

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    nchk = nchk + 1;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Row whose lane i holds base*256 + w*16 + i, so lanes are distinguishable.
  function automatic logic [BW-1:0] mk(input int w, input int base);
    logic [BW-1:0] d;
    for (int i = 0; i < SS; i++) d[i*DW +: DW] = 16'(base * 256 + w * 16 + i);
    return d;
  endfunction

  // Row with every lane equal to the word index.
  function automatic logic [BW-1:0] all_lanes(input int w);
    logic [DW-1:0] v;
    v = 16'(w);
    return {SS{v}};
  endfunction

  // One clock: issue a read (or idle), present last cycle's read data, log outputs.
  task automatic drive(input logic rd, input logic [4:0] szin, input int expsz, input logic [BW-1:0] dat);
    wgt_rdata = rdata_q;
    rdata_q   = dat;
    rd_en_in  = rd;
    size_in   = szin;
    if (n < NLOG) begin
      stim_rd[n]  = rd;
      stim_sz[n]  = expsz;
      stim_dat[n] = dat;
    end
    @(posedge clk);
    #1;
    if (n < NLOG) begin
      log_v[n]    = wgt_valid;
      log_o[n]    = wgt_out;
      log_done[n] = tile_done;
      log_busy[n] = busy;
    end
    n = n + 1;
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) drive(1'b0, 5'd31, 0, '1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rd_en_in = 1'b0;
    size_in = '0;
    wgt_rdata = '0;
    rdata_q = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < NLOG; k++) begin
      stim_rd[k]  = 1'b0;
      stim_sz[k]  = 0;
      stim_dat[k] = '0;
    end
  endtask

  // Compare logged cycles 0..last: lane i shows the word issued i+1 cycles
  // earlier (masked to its expected size); tile_done only at d1/d2; busy in [blo,bhi].
  task automatic check_window(input string name, input int last, input int d1, input int d2,
                              input int blo, input int bhi);
    for (int m = 0; m <= last; m++) begin
      logic [SS-1:0] ev;
      logic [BW-1:0] eo;
      ev = '0;
      eo = '0;
      for (int i = 0; i < SS; i++) begin
        int s;
        s = m - 1 - i;
        if (s >= 0 && stim_rd[s]) begin
          ev[i] = 1'b1;
          if (i < stim_sz[s]) eo[i*DW +: DW] = stim_dat[s][i*DW +: DW];
        end
      end
      chk($sformatf("%s valid@%0d", name, m), BW'(log_v[m]), BW'(ev));
      chk($sformatf("%s data@%0d", name, m), log_o[m], eo);
      chk($sformatf("%s tile_done@%0d", name, m), BW'(log_done[m]), BW'((m == d1) || (m == d2)));
      chk($sformatf("%s busy@%0d", name, m), BW'(log_busy[m]), BW'((m >= blo) && (m <= bhi)));
    end
  endtask

  initial begin
    int word;

    // Reset state
    do_reset();
    chk("rst wgt_valid", BW'(wgt_valid), '0);
    chk("rst wgt_out", wgt_out, '0);
    chk("rst tile_done", BW'(tile_done), '0);
    chk("rst busy", BW'(busy), '0);
`ifdef WGT_TILE_CNT_EN
    chk("rst tile_cnt", BW'(tile_cnt), '0);
    chk("rst err_short", BW'(err_short), '0);
`endif

    // 1: single full tile, size 16, lane data = word index
    for (int w = 0; w < TILE_LEN; w++) drive(1'b1, 5'd16, 16, all_lanes(w));
    idle(20);
    check_window("t1", 46, 42, -1, 1, 42);

    // 2: partial tile, size 5, all-ones data
    do_reset();
    for (int w = 0; w < TILE_LEN; w++) drive(1'b1, 5'd5, 5, '1);
    idle(20);
    check_window("t2", 46, 42, -1, 1, 42);

    // 3: back-to-back tiles, second starts 3 cycles after the first's last word;
    //    size_in changes after each tile's first word must be ignored
    do_reset();
    for (int w = 0; w < TILE_LEN; w++) drive(1'b1, (w == 0) ? 5'd16 : 5'd3, 16, mk(w, 0));
    idle(2);
    for (int w = 0; w < TILE_LEN; w++) drive(1'b1, (w == 0) ? 5'd7 : 5'd20, 7, mk(w, 8'hB0));
    idle(20);
    check_window("t3", 75, 42, 71, 1, 71);

    // 4: bubbles, rd_en pattern 1,1,0,1 until 27 words
    do_reset();
    word = 0;
    for (int g = 0; g < 9; g++) begin
      for (int p = 0; p < 4; p++) begin
        if (p == 2) begin
          idle(1);
        end else begin
          drive(1'b1, 5'd16, 16, mk(word, 8'h20));
          word = word + 1;
        end
      end
    end
    idle(20);
    check_window("t4", 55, 51, -1, 1, 51);
`ifdef WGT_TILE_CNT_EN
    chk("t4 err_short", BW'(err_short), '0);
    chk("t4 tile_cnt", BW'(tile_cnt), BW'(1));
`endif

    // 5: reset mid-FILL after 10 words, then a fresh tile
    do_reset();
    for (int w = 0; w < 10; w++) drive(1'b1, 5'd16, 16, mk(w, 8'h30));
    chk("t5 busy before reset", BW'(busy), BW'(1));
    rst_n = 1'b0;
    #1;
    chk("t5 async wgt_valid", BW'(wgt_valid), '0);
    chk("t5 async wgt_out", wgt_out, '0);
    chk("t5 async tile_done", BW'(tile_done), '0);
    chk("t5 async busy", BW'(busy), '0);
    do_reset();
    idle(30);
    for (int w = 0; w < TILE_LEN; w++) drive(1'b1, 5'd16, 16, mk(w, 8'h50));
    idle(20);
    check_window("t5", 76, 72, -1, 31, 72);

    // 6: size 20 clamps to 16
    do_reset();
    for (int w = 0; w < TILE_LEN; w++) drive(1'b1, 5'd20, 16, mk(w, 8'h40));
    idle(20);
    check_window("t6", 46, 42, -1, 1, 42);
`ifdef WGT_TILE_CNT_EN
    chk("t6 tile_cnt after 1", BW'(tile_cnt), BW'(1));
    for (int t = 0; t < 2; t++) begin
      for (int w = 0; w < TILE_LEN; w++) drive(1'b1, 5'd16, 16, mk(w, t));
      idle(18);
    end
    chk("t6 tile_cnt after 3", BW'(tile_cnt), BW'(3));
    chk("t6 err_short clear", BW'(err_short), '0);
    for (int w = 0; w < 12; w++) drive(1'b1, 5'd16, 16, mk(w, 8'h60));
    idle(4);
    chk("t6 err_short 4-cycle stall", BW'(err_short), '0);
    idle(1);
    drive(1'b1, 5'd16, 16, mk(12, 8'h60));
    chk("t6 err_short 5-cycle stall", BW'(err_short), BW'(1));
    for (int w = 13; w < TILE_LEN; w++) drive(1'b1, 5'd16, 16, mk(w, 8'h60));
    idle(20);
    chk("t6 err_short sticky", BW'(err_short), BW'(1));
    chk("t6 tile_cnt after 4", BW'(tile_cnt), BW'(4));
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
